oam_dma: RTL and testbench

OAM DMA controller for the $4014 register. On a CPU write to $4014 it stalls the CPU, takes ownership of the CPU bus, and copies 256 bytes from CPU page {page, 8'h00..8'hFF} into the PPU's OAMDATA port ($2004) as alternating read/write cycles. It sits between the CPU core, the CPU bus mux and the PPU register port, and runs one step per CPU cycle.

---
 rtl/oam_dma.sv | 158 +++++++++++++++
 tb/tb_oam_dma.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// ----------------------------------------------------------------------------
// oam_dma
//
// OAM DMA controller behind the $4014 register. A CPU write to $4014 starts
// a copy of the 256-byte CPU page {page, 8'h00..8'hFF} into the PPU OAMDATA
// port ($2004). While the copy runs, the CPU is held and the DMA drives the
// CPU bus with alternating read/write cycles. One state step per CPU cycle.
//
// Ports:
//   clk          CPU-cycle clock; one edge is one CPU cycle
//   reset        synchronous, active-high reset
//   reg_wren     decoded CPU write strobe to $4014
//   reg_data     CPU write data: source page number
//   bus_data_in  CPU bus read data, valid combinationally while bus_rden=1
//   cpu_halt     high while the DMA owns the bus (CPU frozen, mux selects DMA)
//   bus_addr     DMA bus address ({page, idx} on reads, $2004 on writes)
//   bus_rden     DMA read strobe
//   bus_wren     DMA write strobe
//   bus_data_out DMA write data; holds the last latched byte outside WRITE
//   done         one-cycle pulse in the cycle after the final write
// ----------------------------------------------------------------------------
module oam_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_wren,
    input  logic [7:0]  reg_data,
    input  logic [7:0]  bus_data_in,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic        bus_rden,
    output logic        bus_wren,
    output logic [7:0]  bus_data_out,
    output logic        done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
    localparam logic [7:0]  LAST_IDX     = 8'hFF;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] latch;
    logic       parity;
    logic       last_write;

    // The final WRITE is the only way back to IDLE apart from reset; it is
    // also what arms the done pulse for the following cycle.
    assign last_write = (state == ST_WRITE) && (idx == LAST_IDX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // Triggers are accepted from IDLE only; writes to $4014 in
                // any other state leave the running copy untouched.
                if (reg_wren) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                // Reads must land on even-parity cycles. If this HALT cycle
                // is odd, the next one is even and the read can start now;
                // otherwise one ALIGN cycle is inserted.
                if (parity) begin
                    state_nxt = ST_READ;
                end else begin
                    state_nxt = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                state_nxt = ST_READ;
            end
            ST_READ: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_READ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, parity and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            latch  <= 8'h00;
            parity <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Free-running CPU cycle parity, 0 in the first cycle after reset.
            parity <= ~parity;
            done   <= last_write;
            case (state)
                ST_IDLE: begin
                    if (reg_wren) begin
                        page <= reg_data;
                        idx  <= 8'h00;
                    end
                end
                ST_READ: begin
                    // The bus device answers combinationally within the READ
                    // cycle, so the byte is captured at its closing edge.
                    latch <= bus_data_in;
                end
                ST_WRITE: begin
                    // idx stops at $FF so the copy never spills into the
                    // next page.
                    if (idx != LAST_IDX) begin
                        idx <= idx + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs, decoded from the state register only (no path from
    // reg_wren to cpu_halt or the strobes).
    // ------------------------------------------------------------------
    always_comb begin
        cpu_halt = (state != ST_IDLE);
        bus_rden = (state == ST_READ);
        bus_wren = (state == ST_WRITE);
        bus_addr = 16'h0000;
        if (state == ST_READ) begin
            bus_addr = {page, idx};
        end else if (state == ST_WRITE) begin
            bus_addr = OAMDATA_ADDR;
        end
    end

    assign bus_data_out = latch;

endmodule

// File: tb/tb_oam_dma.sv
// ----------------------------------------------------------------------------
// tb_oam_dma
//
// Directed bench for oam_dma. A table of transfer scenarios (trigger cycle,
// page, expected first-read cycle, halt length and done cycle) is run through
// a timeline model that predicts every bus cycle; hand-written sequences
// cover reset in mid-transfer and a back-to-back retrigger on the done cycle.
// Cycle 0 is the first cycle after reset is released.
// ----------------------------------------------------------------------------
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_wren = 1'b0;
    logic [7:0]  reg_data = 8'h00;
    logic [7:0]  bus_data_in;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic        bus_rden;
    logic        bus_wren;
    logic [7:0]  bus_data_out;
    logic        done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    oam_dma dut (
        .clk         (clk),
        .reset       (reset),
        .reg_wren    (reg_wren),
        .reg_data    (reg_data),
        .bus_data_in (bus_data_in),
        .cpu_halt    (cpu_halt),
        .bus_addr    (bus_addr),
        .bus_rden    (bus_rden),
        .bus_wren    (bus_wren),
        .bus_data_out(bus_data_out),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Memory image: page $02 holds i ^ $A5; other pages differ so that a
    // wrong page shows up as wrong data.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'hA5 ^ a[15:8] ^ 8'h02;
    endfunction

    assign bus_data_in = bus_rden ? mem_byte(bus_addr) : 8'hEE;

    typedef struct {
        int         trig;
        logic [7:0] pg;
        int         first_rd;
        int         halt_len;
        int         done_cyc;
        int         retrig_k;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        reg_wren = 1'b0;
        reg_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("rst_halt", {31'd0, cpu_halt}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dout", {24'd0, bus_data_out}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Runs one transfer from the current cycle, checking every cycle against
    // a timeline derived from the expected first-read cycle.
    task automatic run_transfer(input int trig, input logic [7:0] pg, input int first_rd,
                                input int halt_len, input int done_cyc, input int retrig_k,
                                input bit chain, input logic [7:0] next_pg,
                                input logic [7:0] prev_dout);
        int          last_cyc;
        int          halt_cnt;
        int          rd_obs;
        int          done_obs;
        int          off;
        int          k;
        logic        e_halt;
        logic        e_rd;
        logic        e_wr;
        logic        e_done;
        logic [15:0] e_addr;
        logic [7:0]  e_dout;
        last_cyc = chain ? done_cyc : done_cyc + 2;
        halt_cnt = 0;
        rd_obs   = -1;
        done_obs = -1;
        while (cyc <= last_cyc) begin
            reg_wren = 1'b0;
            reg_data = 8'h00;
            if (cyc == trig) begin
                reg_wren = 1'b1;
                reg_data = pg;
            end
            if (retrig_k >= 0 && (cyc == first_rd + 2 * retrig_k || cyc == first_rd + 2 * retrig_k + 1)) begin
                reg_wren = 1'b1;
                reg_data = 8'h07;
            end
            if (chain && cyc == done_cyc) begin
                reg_wren = 1'b1;
                reg_data = next_pg;
            end

            off    = cyc - first_rd;
            e_halt = (cyc > trig) && (off <= 511);
            e_rd   = (off >= 0) && (off <= 511) && (off % 2 == 0);
            e_wr   = (off >= 0) && (off <= 511) && (off % 2 == 1);
            e_done = (off == 512);
            k      = (off >= 0) ? off / 2 : 0;
            e_addr = e_rd ? {pg, k[7:0]} : (e_wr ? 16'h2004 : 16'h0000);
            if (off < 1) begin
                e_dout = prev_dout;
            end else begin
                k = (off - 1) / 2;
                if (k > 255) k = 255;
                e_dout = mem_byte({pg, k[7:0]});
            end

            @(negedge clk);
            chk("cpu_halt", {31'd0, cpu_halt}, {31'd0, e_halt});
            chk("bus_rden", {31'd0, bus_rden}, {31'd0, e_rd});
            chk("bus_wren", {31'd0, bus_wren}, {31'd0, e_wr});
            chk("bus_addr", {16'd0, bus_addr}, {16'd0, e_addr});
            chk("bus_data_out", {24'd0, bus_data_out}, {24'd0, e_dout});
            chk("done", {31'd0, done}, {31'd0, e_done});
            if (cpu_halt) halt_cnt++;
            if (bus_rden && rd_obs < 0) rd_obs = cyc;
            if (done && done_obs < 0) done_obs = cyc;

            @(posedge clk);
            #1;
            cyc++;
        end
        reg_wren = 1'b0;
        chk("halt_len", halt_cnt, halt_len);
        chk("first_read", rd_obs, first_rd);
        chk("done_cycle", done_obs, done_cyc);
    endtask

    initial begin
        // trig, page, first read, halt cycles, done cycle, retrigger index
        vecs[0] = '{4, 8'h02, 6, 513, 518, -1};   // even trigger
        vecs[1] = '{5, 8'h02, 8, 514, 520, -1};   // odd trigger
        vecs[2] = '{4, 8'hFF, 6, 513, 518, -1};   // last page, ends at $FFFF
        vecs[3] = '{4, 8'h02, 6, 513, 518, 10};   // $07 written during idx 10

        for (int v = 0; v < 4; v++) begin
            do_reset();
            run_transfer(vecs[v].trig, vecs[v].pg, vecs[v].first_rd, vecs[v].halt_len,
                         vecs[v].done_cyc, vecs[v].retrig_k, 1'b0, 8'h00, 8'h00);
        end

        // Reset asserted during the READ of idx 100 (cycle 6 + 200).
        do_reset();
        while (cyc < 206) begin
            reg_wren = (cyc == 4);
            reg_data = 8'h02;
            @(posedge clk);
            #1;
            cyc++;
        end
        reg_wren = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("mid_rden", {31'd0, bus_rden}, 32'd1);
        chk("mid_addr", {16'd0, bus_addr}, 32'h0000_0264);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        // Cycle 0 here is the cycle right after the reset edge: everything
        // idle, latch cleared, no done, and a fresh copy from idx 0.
        run_transfer(4, 8'h03, 6, 513, 518, -1, 1'b0, 8'h00, 8'h00);

        // Back-to-back: odd trigger, then retrigger in the done cycle.
        do_reset();
        run_transfer(5, 8'h02, 8, 514, 520, -1, 1'b1, 8'h40, 8'h00);
        run_transfer(520, 8'h40, 522, 513, 1034, -1, 1'b0, 8'h00, mem_byte(16'h02FF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule
